// File: rtl/dadda_pkg.sv
// Shared widths for the dot-product MAC: default operand and guard widths,
// the accumulator width rule and the saturating beat-counter width.
package dadda_pkg;

    localparam int N_DEF = 32;
    localparam int G_DEF = 8;
    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic int acc_w(input int n, input int g);
        return 2 * n + g;
    endfunction

endpackage

// File: rtl/dadda_mac_if.sv
// Beat-in / result-out bus of the dot-product MAC.
interface dadda_mac_if
    import dadda_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int G = G_DEF
);
    localparam int ACC_W = acc_w(N, G);

    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [ACC_W-1:0] acc_out;
    logic [CNT_W-1:0] out_count;
    logic             out_overflow;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, in_valid, in_last, out_ready,
        input  in_ready, acc_out, out_count, out_overflow, out_valid
    );

    modport slave (
        input  a, b, in_valid, in_last, out_ready,
        output in_ready, acc_out, out_count, out_overflow, out_valid
    );

endinterface

// File: rtl/dadda_multiplier.sv
// Unsigned N x N multiplier: partial products folded through a carry-save
// chain of 3:2 compressors, one carry-propagate add at the end.
module dadda_multiplier
    import dadda_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    logic [2*N-1:0] sum_s;
    logic [2*N-1:0] carry_s;
    logic [2*N-1:0] pp_s;
    logic [2*N-1:0] nsum_s;

    // Fold each partial product into the redundant (sum, carry) pair; the product fits in 2N bits so truncation is exact.
    always_comb begin
        sum_s   = '0;
        carry_s = '0;
        pp_s    = '0;
        nsum_s  = '0;
        for (int i = 0; i < N; i++) begin
            if (b[i]) begin
                pp_s = {{N{1'b0}}, a} << i;
            end else begin
                pp_s = '0;
            end
            nsum_s  = sum_s ^ carry_s ^ pp_s;
            carry_s = ((sum_s & carry_s) | (sum_s & pp_s) | (carry_s & pp_s)) << 1;
            sum_s   = nsum_s;
        end
    end

    assign p = sum_s + carry_s;

endmodule

// File: rtl/dadda_mac.sv
// Two-stage streaming dot-product MAC: stage 1 registers operands, stage 2
// accumulates the product and hands finished vectors to a held output register.
module dadda_mac
    import dadda_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int G = G_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    dadda_mac_if.slave  bus
);

    localparam int ACC_W = acc_w(N, G);

    logic [N-1:0]     s1_a_r;
    logic [N-1:0]     s1_b_r;
    logic             s1_last_r;
    logic             s1_valid_r;
    logic [2*N-1:0]   prod_s;

    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ovf_r;
    logic [ACC_W-1:0] sum_s;
    logic             carry_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             ovf_next_s;

    logic [ACC_W-1:0] out_acc_r;
    logic [CNT_W-1:0] out_cnt_r;
    logic             out_ovf_r;
    logic             out_valid_r;

    logic             s1_adv_s;
    logic             beat_xfer_s;
    logic             res_load_s;

    // Only a last beat can be blocked, and only by an undelivered result.
    assign s1_adv_s    = s1_valid_r && (!s1_last_r || !out_valid_r || bus.out_ready);
    assign bus.in_ready = rst_n && (!s1_valid_r || s1_adv_s);
    assign beat_xfer_s = bus.in_valid && bus.in_ready;
    assign res_load_s  = s1_adv_s && s1_last_r;

    dadda_multiplier #(.N(N)) u_mult (
        .a (s1_a_r),
        .b (s1_b_r),
        .p (prod_s)
    );

    // Accumulate with carry capture; acc/cnt/ovf sit at zero between vectors, so a first beat needs no special case.
    always_comb begin
        {carry_s, sum_s} = {1'b0, acc_r} + {{(G + 1){1'b0}}, prod_s};
        ovf_next_s       = ovf_r | carry_s;
        if (cnt_r == CNT_MAX) begin
            cnt_next_s = cnt_r;
        end else begin
            cnt_next_s = cnt_r + CNT_ONE;
        end
    end

    // Stage 1 operand register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a_r     <= '0;
            s1_b_r     <= '0;
            s1_last_r  <= 1'b0;
            s1_valid_r <= 1'b0;
        end else if (beat_xfer_s) begin
            s1_a_r     <= bus.a;
            s1_b_r     <= bus.b;
            s1_last_r  <= bus.in_last;
            s1_valid_r <= 1'b1;
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2 running sum, beat count and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
            cnt_r <= '0;
            ovf_r <= 1'b0;
        end else if (res_load_s) begin
            acc_r <= '0;
            cnt_r <= '0;
            ovf_r <= 1'b0;
        end else if (s1_adv_s) begin
            acc_r <= sum_s;
            cnt_r <= cnt_next_s;
            ovf_r <= ovf_next_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    // Result register: a new result may replace one being taken on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_acc_r   <= '0;
            out_cnt_r   <= '0;
            out_ovf_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (res_load_s) begin
            out_acc_r   <= sum_s;
            out_cnt_r   <= cnt_next_s;
            out_ovf_r   <= ovf_next_s;
            out_valid_r <= 1'b1;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.acc_out      = out_acc_r;
    assign bus.out_count    = out_cnt_r;
    assign bus.out_overflow = out_ovf_r;
    assign bus.out_valid    = out_valid_r;

endmodule

// File: tb/tb_dadda_mac.sv
// Scoreboard bench for dadda_mac: stimulus pushes expected results, a monitor
// pops and compares on every result transfer.
module tb_dadda_mac;
    import dadda_pkg::*;

    localparam int N     = 32;
    localparam int G     = 8;
    localparam int ACC_W = acc_w(N, G);

    typedef struct packed {
        logic [ACC_W-1:0] acc;
        logic [15:0]      cnt;
        logic             ovf;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    dadda_mac_if #(.N(N), .G(G)) bus();

    dadda_mac #(.N(N), .G(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    res_t sb[$];
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   n_out    = 0;
    int   n_pushed = 0;
    int   cyc      = 0;
    bit   rnd_ready  = 1'b0;
    bit   stall_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [ACC_W-1:0] acc, input logic [15:0] cnt, input logic ovf);
        res_t r;
        r.acc = acc;
        r.cnt = cnt;
        r.ovf = ovf;
        sb.push_back(r);
        n_pushed++;
    endtask

    task automatic send_beat(input logic [N-1:0] a, input logic [N-1:0] b, input logic last);
        int t;
        bus.a        = a;
        bus.b        = b;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        if (!bus.in_ready) stall_seen = 1'b1;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_in_ready"},     96'(bus.in_ready),     96'd0);
        check({tag, "_out_valid"},    96'(bus.out_valid),    96'd0);
        check({tag, "_acc_out"},      96'(bus.acc_out),      96'd0);
        check({tag, "_out_count"},    96'(bus.out_count),    96'd0);
        check({tag, "_out_overflow"}, 96'(bus.out_overflow), 96'd0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() > 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_queue_empty", 96'(sb.size()), 96'd0);
    endtask

    // Random or held consumer back-pressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compare on every result transfer and check hold stability.
    initial begin
        res_t e;
        res_t prev;
        res_t cur;
        logic pv;
        logic pr;
        pv = 1'b0;
        pr = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {bus.acc_out, bus.out_count, bus.out_overflow};
            if (rst_n && pv && !pr) begin
                check("hold_valid",  96'(bus.out_valid), 96'd1);
                check("hold_fields", 96'(cur), 96'(prev));
            end
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: got acc %0h count %0d expected none", bus.acc_out, bus.out_count);
                end else begin
                    e = sb.pop_front();
                    check("acc_out",      96'(bus.acc_out),      96'(e.acc));
                    check("out_count",    96'(bus.out_count),    96'(e.cnt));
                    check("out_overflow", 96'(bus.out_overflow), 96'(e.ovf));
                    n_out++;
                end
            end
            pv   = rst_n && bus.out_valid;
            pr   = bus.out_ready;
            prev = cur;
        end
    end

    initial begin
        int            c0;
        int            t;
        int            len;
        logic [N-1:0]  ra;
        logic [N-1:0]  rb;
        logic [95:0]   tot;

        bus.a         = '0;
        bus.b         = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 96'(bus.in_ready), 96'd1);
        @(posedge clk);
        #1;

        // Single beat with latency measurement.
        c0 = cyc;
        push_exp(72'd15, 16'd1, 1'b0);
        send_beat(32'd3, 32'd5, 1'b1);
        t = 0;
        while (!bus.out_valid && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("latency", 96'(cyc - c0), 96'd2);
        drain();
        @(posedge clk);
        #1;

        // Four beats back-to-back.
        stall_seen = 1'b0;
        push_exp(72'd100, 16'd4, 1'b0);
        send_beat(32'd1, 32'd2, 1'b0);
        send_beat(32'd3, 32'd4, 1'b0);
        send_beat(32'd5, 32'd6, 1'b0);
        send_beat(32'd7, 32'd8, 1'b1);
        check("no_stall_streaming", 96'(stall_seen), 96'd0);
        drain();
        @(posedge clk);
        #1;

        // Two single-beat vectors behind a stalled consumer.
        bus.out_ready = 1'b0;
        push_exp(72'd6, 16'd1, 1'b0);
        send_beat(32'd2, 32'd3, 1'b1);
        push_exp(72'd20, 16'd1, 1'b0);
        send_beat(32'd4, 32'd5, 1'b1);
        @(negedge clk);
        check("in_ready_blocked", 96'(bus.in_ready), 96'd0);
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain();
        @(posedge clk);
        #1;

        // Overflow across 257 max beats, then none across 256.
        push_exp(72'h00FFFFFDFE00000101, 16'd257, 1'b1);
        for (int i = 0; i < 257; i++) send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, (i == 256) ? 1'b1 : 1'b0);
        push_exp(72'hFFFFFFFE0000000100, 16'd256, 1'b0);
        for (int i = 0; i < 256; i++) send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, (i == 255) ? 1'b1 : 1'b0);
        drain();
        @(posedge clk);
        #1;

        // Reset in the middle of a vector.
        send_beat(32'd9, 32'd9, 1'b0);
        send_beat(32'd9, 32'd9, 1'b0);
        rst_n = 1'b0;
        sb.delete();
        check_reset_outputs("midreset_c1");
        check_reset_outputs("midreset_c2");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_midreset", 96'(bus.in_ready), 96'd1);
        @(posedge clk);
        #1;
        n_pushed = n_out;
        push_exp(72'd6, 16'd1, 1'b0);
        send_beat(32'd2, 32'd3, 1'b1);
        drain();
        @(posedge clk);
        #1;

        // Random vectors against a wide sum-of-products model.
        rnd_ready = 1'b1;
        for (int v = 0; v < 1000; v++) begin
            len = $urandom_range(1, 20);
            tot = '0;
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    ra = 32'hFFFFFFFF;
                    rb = 32'hFFFFFFFF;
                end else begin
                    ra = $urandom;
                    rb = $urandom;
                end
                tot = tot + ({64'd0, ra} * {64'd0, rb});
                if (k == len - 1) push_exp(tot[ACC_W-1:0], 16'(len), |tot[95:ACC_W]);
                send_beat(ra, rb, (k == len - 1) ? 1'b1 : 1'b0);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        rnd_ready = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        check("results_delivered", 96'(n_out), 96'(n_pushed));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dadda_mac.md
DADDA_MAC -- requirements
Module: dadda_mac

Interface
REQ-001 Parameter N, default 32: operand width in bits.
REQ-002 Parameter G, default 8: accumulator guard bits; accumulator width ACC_W = 2N+G.
REQ-003 clk  input  1  rising-edge clock, the only clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 a  input  N  unsigned multiplicand.
REQ-006 b  input  N  unsigned multiplier.
REQ-007 in_valid  input  1  beat (a, b, in_last) is valid.
REQ-008 in_last  input  1  beat is the final beat of the current vector.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 acc_out  output  ACC_W  dot-product result of the completed vector.
REQ-011 out_count  output  16  number of beats in the completed vector, saturating.
REQ-012 out_overflow  output  1  accumulator carry-out occurred during the vector.
REQ-013 out_valid  output  1  result fields are valid.
REQ-014 out_ready  input  1  consumer accepts the result.

Function
REQ-015 A beat transfers on a rising edge where in_valid && in_ready; a result transfers on a rising edge where out_valid && out_ready.
REQ-016 Stage 1 shall register a, b and in_last on transfer into s1_a, s1_b, s1_last and set s1_valid; the product comes combinationally from s1_a * s1_b through the existing multiplier and is 2N bits wide.
REQ-017 Stage 2 accumulator: on s1 advance, acc <= (first beat of vector ? 0 : acc) + zero-extended product, modulo 2^ACC_W.
REQ-018 Overflow: a carry out of bit ACC_W-1 on any add sets the per-vector sticky flag; the flag clears when a vector starts.
REQ-019 Beat counter: 1 on the first beat, then +1 per beat, saturating at 16'hFFFF.
REQ-020 When s1_last advances, the final sum, count and flag load into the output register and out_valid is set; acc, count and flag return to the first-beat state.
REQ-021 A single-beat vector (first beat with in_last=1) produces acc_out = a*b and out_count = 1.
REQ-022 s1 advances when s1_valid && (!s1_last || !out_valid || out_ready); non-last beats never stall.
REQ-023 in_ready = !s1_valid || s1 advance; it is combinational from out_ready and the registered state.
REQ-024 out_valid clears on result transfer unless a new result loads on the same edge, in which case the new result replaces the old one.
REQ-025 Output fields are held stable while out_valid && !out_ready.
REQ-026 Latency: with no stall, a last beat presented in cycle c produces out_valid in cycle c+2; sustained throughput is 1 beat per cycle.
REQ-027 Results are delivered in vector order with no loss or duplication under arbitrary out_ready patterns.

Reset
REQ-028 While rst_n is low: in_ready=0, out_valid=0, acc_out=0, out_count=0, out_overflow=0, s1_valid=0, acc=0; the next beat is treated as a first beat.
REQ-029 Reset asserted mid-vector discards the partial vector and any undelivered result; no output is produced for it.
REQ-030 in_ready shall be 1 in the first cycle after rst_n deasserts.

Structure
REQ-031 Package dadda_pkg shall hold the default N, default G, the ACC_W function/localparam and the count width (16).
REQ-032 The existing dadda_multiplier is the single sub-module, instantiated once on s1_a/s1_b; there is no other hierarchy.

Verification
REQ-033 Single beat a=3, b=5, last, out_ready=1 -> acc_out=15, out_count=1, out_overflow=0, out_valid exactly 2 cycles after presentation.
REQ-034 Vector (1,2),(3,4),(5,6),(7,8) streamed back-to-back -> acc_out=100, out_count=4, in_ready held 1.
REQ-035 Two vectors {(2,3)} and {(4,5)} with out_ready=0 for 6 cycles -> in_ready drops while the second last beat sits in s1; then 6 then 20 delivered in order.
REQ-036 257 beats of a=b=32'hFFFFFFFF -> out_overflow=1, out_count=257, acc_out = 257*(2^64-2^33+1) mod 2^72; a following 256-beat vector of the same values -> out_overflow=0.
REQ-037 Two beats (9,9),(9,9) then rst_n low for 2 cycles, then vector {(2,3), last} -> no output for the first vector; acc_out=6, out_count=1.
REQ-038 1000 random vectors of lengths 1-20 with random in_valid/out_ready -> every result matches a behavioural sum-of-products model, including overflow and count.
